// File: rtl/xadc_drp_classifier_if.sv
// DRP bus between the classifier (master) and the XADC primitive (slave).
interface xadc_drp_classifier_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
  modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);
endinterface

// File: rtl/xadc_drp_classifier.sv
// Sweeps NUM_CH XADC aux channels over DRP, keeps per-channel results and publishes the argmax class.
// Define XADC_CLASS_IIR_EN to smooth each channel with a per-channel IIR before storage and argmax.
module xadc_drp_classifier #(
  parameter int         NUM_CH   = 4,
  parameter int         SAMPLE_W = 12,
  parameter logic [6:0] DRP_BASE = 7'h10,
  parameter int         TIMEOUT  = 64,
  localparam int        CLS_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic                         enable,
  input  logic                         eos_trig,
  input  logic [SAMPLE_W-1:0]          threshold,
  xadc_drp_classifier_if.master        drp,
  input  logic                         EOS,
  output logic [NUM_CH*SAMPLE_W-1:0]   samples,
  output logic [CLS_W-1:0]             class_out,
  output logic                         class_above,
  output logic                         class_valid,
  output logic                         timeout_err,
  output logic [15:0]                  sweep_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_REQ, ST_WAIT, ST_NEXT, ST_PUBLISH} state_t;

  state_t              state;
  logic [CLS_W-1:0]    ch;
  logic [CLS_W-1:0]    max_idx;
  logic [SAMPLE_W-1:0] max_val;
  logic [SAMPLE_W-1:0] raw;
  logic [SAMPLE_W-1:0] val;
  logic [TW-1:0]       tcnt;
  logic                abort;
  logic                last_ch;
  logic                timed_out;

  assign drp.DWE   = 1'b0;
  assign drp.DI    = '0;
  assign raw       = drp.DO[15 -: SAMPLE_W];
  assign last_ch   = (ch == CLS_W'(NUM_CH - 1));
  assign timed_out = (tcnt == TW'(TIMEOUT - 1));

`ifdef XADC_CLASS_IIR_EN
  logic [SAMPLE_W+1:0]        filt [NUM_CH];
  logic signed [SAMPLE_W+2:0] diff;
  logic signed [SAMPLE_W+2:0] acc;

  // One guard bit above the filter state keeps (x - f) and the sum free of overflow.
  always_comb begin
    diff = $signed({1'b0, raw, 2'b00}) - $signed({1'b0, filt[ch]});
    acc  = $signed({1'b0, filt[ch]}) + (diff >>> 2);
    val  = acc[SAMPLE_W+1:2];
  end
`else
  assign val = raw;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state       <= ST_IDLE;
      ch          <= '0;
      max_idx     <= '0;
      max_val     <= '0;
      tcnt        <= '0;
      abort       <= 1'b0;
      drp.DADDR   <= '0;
      drp.DEN     <= 1'b0;
      samples     <= '0;
      class_out   <= '0;
      class_above <= 1'b0;
      class_valid <= 1'b0;
      timeout_err <= 1'b0;
      sweep_count <= '0;
`ifdef XADC_CLASS_IIR_EN
      for (int k = 0; k < NUM_CH; k++) filt[k] <= '0;
`endif
    end else begin
      drp.DEN     <= 1'b0;
      class_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_ARM;
        end
        ST_ARM: begin
          abort <= 1'b0;
          if (!enable) begin
            state <= ST_IDLE;
          end else if (!eos_trig || EOS) begin
            state     <= ST_REQ;
            drp.DEN   <= 1'b1;
            drp.DADDR <= DRP_BASE + 7'(ch);
          end
        end
        ST_REQ: begin
          tcnt  <= '0;
          if (!enable) abort <= 1'b1;
          state <= ST_WAIT;
        end
        // A dropped enable is remembered so the in-flight read finishes before bailing out.
        ST_WAIT: begin
          if (!enable) abort <= 1'b1;
          if (drp.DRDY) begin
            samples[ch*SAMPLE_W +: SAMPLE_W] <= val;
`ifdef XADC_CLASS_IIR_EN
            filt[ch] <= acc[SAMPLE_W+1:0];
`endif
            if (ch == '0 || val > max_val) begin
              max_val <= val;
              max_idx <= ch;
            end
            state <= ST_NEXT;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            if (ch == '0) begin
              max_val <= '0;
              max_idx <= '0;
            end
            state <= ST_NEXT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (abort || !enable) begin
            state   <= ST_IDLE;
            ch      <= '0;
            max_val <= '0;
            max_idx <= '0;
          end else if (last_ch) begin
            ch    <= '0;
            state <= ST_PUBLISH;
          end else begin
            ch        <= ch + 1'b1;
            state     <= ST_REQ;
            drp.DEN   <= 1'b1;
            drp.DADDR <= DRP_BASE + 7'(ch + 1'b1);
          end
        end
        ST_PUBLISH: begin
          class_out   <= max_idx;
          class_above <= (max_val >= threshold);
          class_valid <= 1'b1;
          sweep_count <= sweep_count + 16'd1;
          state       <= enable ? ST_ARM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_classifier.sv
// Directed bench for xadc_drp_classifier with a DRP slave model answering 3 cycles after each DEN.
module tb_xadc_drp_classifier;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        eos_trig;
  logic [11:0] threshold;
  logic        eos;
  logic [47:0] samples;
  logic [1:0]  class_out;
  logic        class_above;
  logic        class_valid;
  logic        timeout_err;
  logic [15:0] sweep_count;

  xadc_drp_classifier_if drp ();

  xadc_drp_classifier dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .enable        (enable),
    .eos_trig      (eos_trig),
    .threshold     (threshold),
    .drp           (drp),
    .EOS           (eos),
    .samples       (samples),
    .class_out     (class_out),
    .class_above   (class_above),
    .class_valid   (class_valid),
    .timeout_err   (timeout_err),
    .sweep_count   (sweep_count)
  );

  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  int          hold_ch = -1;
  time         drdy_time = 0;
  time         valid_time = 0;
  logic [15:0] do_tab [4];
  logic [6:0]  addr_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] d3, input logic [11:0] thr, input int hold);
    do_tab[0] = d0;
    do_tab[1] = d1;
    do_tab[2] = d2;
    do_tab[3] = d3;
    threshold = thr;
    hold_ch   = hold;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitValid(input int budget, input string tag);
    int  start;
    bit  got;
    start = valid_cnt;
    got   = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #2;
      if (valid_cnt != start) got = 1'b1;
    end
    checkOutput(tag, 64'(got), 64'd1);
  endtask

  task automatic waitDen(input int count, input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #2;
      if (addr_q.size() >= count) got = 1'b1;
    end
    checkOutput(tag, 64'(got), 64'd1);
  endtask

  function automatic logic [11:0] smp(input int k);
    return samples[k*12 +: 12];
  endfunction

  // DRP slave: DRDY is presented 3 cycles after the DEN cycle unless that channel is withheld.
  initial begin : drp_slave
    int a;
    drp.DRDY = 1'b0;
    drp.DO   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (drp.DEN) begin
        a = int'(drp.DADDR) - 16;
        if (a >= 0 && a < 4 && a != hold_ch) begin
          repeat (3) @(posedge clk);
          #1;
          drp.DO    = do_tab[a];
          drp.DRDY  = 1'b1;
          drdy_time = $time;
          @(posedge clk);
          #1;
          drp.DRDY = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (drp.DEN) addr_q.push_back(drp.DADDR);
      if (class_valid) begin
        valid_cnt++;
        valid_time = $time;
      end
    end
  end

  initial begin : main
    int base;
    int vbase;
`ifdef XADC_CLASS_IIR_EN
    logic [11:0] iir_exp [3];
`endif
    rst_n     = 1'b0;
    enable    = 1'b0;
    eos_trig  = 1'b0;
    threshold = '0;
    eos       = 1'b0;
    applyStimulus(16'h0, 16'h0, 16'h0, 16'h0, 12'h0, -1);
    cycles(3);
    checkOutput("rst_samples", 64'(samples), 64'h0);
    checkOutput("rst_class_out", 64'(class_out), 64'h0);
    checkOutput("rst_class_above", 64'(class_above), 64'h0);
    checkOutput("rst_class_valid", 64'(class_valid), 64'h0);
    checkOutput("rst_timeout_err", 64'(timeout_err), 64'h0);
    checkOutput("rst_sweep_count", 64'(sweep_count), 64'h0);
    checkOutput("rst_den", 64'(drp.DEN), 64'h0);
    checkOutput("rst_daddr", 64'(drp.DADDR), 64'h0);
    checkOutput("dwe_di_tied", {47'h0, drp.DWE, drp.DI}, 64'h0);
    rst_n = 1'b1;
    cycles(2);

`ifdef XADC_CLASS_IIR_EN
    iir_exp[0] = 12'h200;
    iir_exp[1] = 12'h380;
    iir_exp[2] = 12'h4A0;
    applyStimulus(16'h8000, 16'h8000, 16'h8000, 16'h8000, 12'h0, -1);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitValid(200, "iir_valid");
      checkOutput("iir_sample0", 64'(smp(0)), 64'(iir_exp[i]));
      checkOutput("iir_class_out", 64'(class_out), 64'h0);
    end
    enable = 1'b0;
    cycles(5);
`else
    // Basic sweep: address order, sample packing, argmax and publish latency.
    applyStimulus(16'h1230, 16'h8000, 16'h4560, 16'h0010, 12'h7FF, -1);
    base   = addr_q.size();
    enable = 1'b1;
    waitValid(200, "sweep1_valid");
    enable = 1'b0;
    checkOutput("sweep1_den_count", 64'(addr_q.size() - base), 64'd4);
    if (addr_q.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) checkOutput("sweep1_daddr", 64'(addr_q[base+k]), 64'(7'h10 + k));
    end
    checkOutput("sweep1_latency", 64'(valid_time - drdy_time), 64'd30);
    checkOutput("sweep1_s0", 64'(smp(0)), 64'h123);
    checkOutput("sweep1_s1", 64'(smp(1)), 64'h800);
    checkOutput("sweep1_s2", 64'(smp(2)), 64'h456);
    checkOutput("sweep1_s3", 64'(smp(3)), 64'h001);
    checkOutput("sweep1_class_out", 64'(class_out), 64'd1);
    checkOutput("sweep1_class_above", 64'(class_above), 64'd1);
    checkOutput("sweep1_count", 64'(sweep_count), 64'd1);
    cycles(1);
    checkOutput("sweep1_valid_pulse", 64'(class_valid), 64'd0);
    cycles(5);

    // Tie between ch1 and ch3 keeps the lower index.
    applyStimulus(16'h0000, 16'hFFF0, 16'h0000, 16'hFFF0, 12'h7FF, -1);
    enable = 1'b1;
    waitValid(200, "tie_valid");
    enable = 1'b0;
    checkOutput("tie_class_out", 64'(class_out), 64'd1);
    checkOutput("tie_count", 64'(sweep_count), 64'd2);
    cycles(5);

    // All equal and below threshold.
    applyStimulus(16'h1000, 16'h1000, 16'h1000, 16'h1000, 12'hF00, -1);
    enable = 1'b1;
    waitValid(200, "below_valid");
    enable = 1'b0;
    checkOutput("below_class_out", 64'(class_out), 64'd0);
    checkOutput("below_class_above", 64'(class_above), 64'd0);
    checkOutput("below_s2", 64'(smp(2)), 64'h100);
    checkOutput("below_count", 64'(sweep_count), 64'd3);
    cycles(5);

    // ch2 never answers: timeout, old sample retained, sweep still publishes.
    checkOutput("pre_timeout_err", 64'(timeout_err), 64'd0);
    applyStimulus(16'h0100, 16'h0200, 16'h7770, 16'h0300, 12'h000, 2);
    enable = 1'b1;
    waitValid(400, "timeout_valid");
    enable = 1'b0;
    checkOutput("timeout_err", 64'(timeout_err), 64'd1);
    checkOutput("timeout_s2_kept", 64'(smp(2)), 64'h100);
    checkOutput("timeout_s3", 64'(smp(3)), 64'h030);
    checkOutput("timeout_class_out", 64'(class_out), 64'd3);
    checkOutput("timeout_count", 64'(sweep_count), 64'd4);
    cycles(5);

    // EOS-triggered: nothing until EOS, then exactly one sweep.
    applyStimulus(16'h0500, 16'h0600, 16'h0400, 16'h0100, 12'h7FF, -1);
    eos_trig = 1'b1;
    enable   = 1'b1;
    base     = addr_q.size();
    vbase    = valid_cnt;
    cycles(20);
    checkOutput("eos_no_den", 64'(addr_q.size() - base), 64'd0);
    eos = 1'b1;
    cycles(1);
    eos = 1'b0;
    waitValid(200, "eos_valid");
    cycles(40);
    checkOutput("eos_den_count", 64'(addr_q.size() - base), 64'd4);
    checkOutput("eos_one_publish", 64'(valid_cnt - vbase), 64'd1);
    checkOutput("eos_class_out", 64'(class_out), 64'd1);
    checkOutput("eos_class_above", 64'(class_above), 64'd0);
    checkOutput("eos_count", 64'(sweep_count), 64'd5);
    enable   = 1'b0;
    eos_trig = 1'b0;
    cycles(5);

    // Drop enable while waiting on ch1: read completes, no publish.
    applyStimulus(16'h0110, 16'h0AB0, 16'h0220, 16'h0330, 12'h000, -1);
    base   = addr_q.size();
    vbase  = valid_cnt;
    enable = 1'b1;
    waitDen(base + 2, 100, "abort_den_seen");
    cycles(1);
    enable = 1'b0;
    cycles(30);
    checkOutput("abort_den_count", 64'(addr_q.size() - base), 64'd2);
    checkOutput("abort_no_publish", 64'(valid_cnt - vbase), 64'd0);
    checkOutput("abort_count", 64'(sweep_count), 64'd5);
    checkOutput("abort_s1_done", 64'(smp(1)), 64'h0AB);
    base   = addr_q.size();
    enable = 1'b1;
    waitValid(200, "restart_valid");
    enable = 1'b0;
    if (addr_q.size() > base) checkOutput("restart_daddr", 64'(addr_q[base]), 64'h10);
    checkOutput("restart_class_out", 64'(class_out), 64'd1);
    checkOutput("restart_class_above", 64'(class_above), 64'd1);
    checkOutput("restart_count", 64'(sweep_count), 64'd6);
    cycles(5);

    // Reset mid-WAIT; the late DRDY must be ignored.
    base   = addr_q.size();
    enable = 1'b1;
    waitDen(base + 1, 100, "rstwait_den_seen");
    cycles(1);
    rst_n  = 1'b0;
    enable = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(10);
    checkOutput("rstwait_samples", 64'(samples), 64'h0);
    checkOutput("rstwait_class_out", 64'(class_out), 64'h0);
    checkOutput("rstwait_class_above", 64'(class_above), 64'h0);
    checkOutput("rstwait_timeout_err", 64'(timeout_err), 64'h0);
    checkOutput("rstwait_count", 64'(sweep_count), 64'h0);
    checkOutput("rstwait_no_den", 64'(addr_q.size() - base), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xadc_drp_classifier.md
Name: xadc_drp_classifier

Overview:
Parametrised successor to the fixed 4-channel XADC front end. It reads NUM_CH auxiliary XADC channels over the DRP port in sweeps, with a DRDY timeout, and keeps per-channel 12-bit results. It computes a running argmax during each sweep and publishes a class index with a threshold-qualified flag. It sits between the XADC primitive and the AXI config register block, and replaces the hard-wired network_output path.

Parameters:
NUM_CH, 4, number of aux channels polled (1..16); channel k is read at DRP address DRP_BASE+k.
SAMPLE_W, 12, result width; taken from DO[15:16-SAMPLE_W].
DRP_BASE, 7'h10, DRP address of VAUX0 status register.
TIMEOUT, 64, cycles to wait for DRDY before abandoning a read.
CLS_W, max(1,$clog2(NUM_CH)), class index width (localparam).

Ports:
S_AXI_ACLK  in  1  clock, also XADC DCLK.
S_AXI_ARESETN  in  1  synchronous active-low reset.
enable  in  1  run sweeps while high.
eos_trig  in  1  1: start each sweep on XADC EOS pulse; 0: back-to-back sweeps.
threshold  in  SAMPLE_W  minimum winner value for class_above.
DADDR  out  7  DRP address.
DEN  out  1  DRP enable, single-cycle pulse.
DWE  out  1  DRP write enable, tied 0 (read only).
DI  out  16  DRP write data, tied 0.
DO  in  16  DRP read data.
DRDY  in  1  DRP read-data strobe.
EOS  in  1  XADC end-of-sequence pulse.
samples  out  NUM_CH*SAMPLE_W  latest per-channel results, ch0 in LSBs.
class_out  out  CLS_W  argmax channel of last completed sweep.
class_above  out  1  winner value >= threshold.
class_valid  out  1  one-cycle pulse on publish.
timeout_err  out  1  sticky; set on any DRDY timeout; cleared only by reset.
sweep_count  out  16  completed sweeps, wraps 0xFFFF->0.

Behaviour:
- Reset (S_AXI_ARESETN=0 at clock edge): all outputs 0, FSM IDLE, channel index 0, running max 0. Takes effect mid-transaction; a late DRDY after reset is ignored.
- FSM states: IDLE, ARM, REQ, WAIT, NEXT, PUBLISH.
- IDLE: if enable, go to ARM.
- ARM: if eos_trig=0, go to REQ. If eos_trig=1, wait for EOS=1, then go to REQ. In ARM, deasserting enable returns to IDLE.
- REQ: drive DEN=1 and DADDR=DRP_BASE+ch for exactly one cycle, clear the timeout counter, then go to WAIT.
- WAIT: on DRDY=1:
  - samples[ch] <= DO[15:16-SAMPLE_W];
  - if ch==0 or value > running max, then max <= value and max_idx <= ch (strict >, so ties keep the lowest index);
  - go to NEXT.
- WAIT timeout: if TIMEOUT cycles elapse without DRDY, set timeout_err, leave samples[ch] unchanged, treat the value as 0 for the argmax, and go to NEXT.
- NEXT: if ch==NUM_CH-1, set ch <= 0 and go to PUBLISH; otherwise ch <= ch+1 and go to REQ.
- PUBLISH (one cycle):
  - class_out <= max_idx; class_above <= (max >= threshold);
  - class_valid=1; sweep_count += 1;
  - go to ARM if enable, else IDLE.
- Outputs are registered. class_valid asserts 2 cycles after the clock edge that samples DRDY for the last channel.
- Enable deasserted mid-sweep (REQ/WAIT/NEXT): the outstanding DRP read still completes or times out, then the FSM goes to IDLE without publishing; ch and max are reset.
- DRDY outside WAIT: ignored.
- EOS outside ARM: ignored.
- BUSY is not used. DRP reads are legal during conversion.
- Minimum sweep length for NUM_CH=4 with DRDY latency L: 4*(L+2)+1 cycles.

Optional Feature:
Macro XADC_CLASS_IIR_EN.
- Defined: each channel keeps a SAMPLE_W+2 bit IIR state, f <= f + (x - f)>>2, computed with signed arithmetic and no overflow. samples and the argmax use f[SAMPLE_W+1:2]. Reset clears f. A timed-out read leaves f unchanged.
- Undefined: raw samples are used directly and no filter registers are built.

Test Plan:
- Reset, then enable=1, eos_trig=0, NUM_CH=4, DRDY 3 cycles after each DEN, DO={0x1230,0x8000,0x4560,0x0010} -> DADDR sequence 0x10,0x11,0x12,0x13; samples={0x001,0x456,0x800,0x123}; class_out=1; class_above=1 with threshold=0x7FF; sweep_count=1.
- Tie: DO ch1=ch3=0xFFF0, others 0 -> class_out=1.
- threshold=0xF00, all DO=0x1000 -> class_out=0, class_above=0, class_valid still pulses.
- Withhold DRDY for ch2 -> after 64 cycles timeout_err=1, sweep completes, samples[2] keeps its old value, and publish occurs.
- eos_trig=1 -> no DEN until an EOS pulse, exactly one sweep per EOS. Drop enable during WAIT for ch1 -> after DRDY, FSM reaches IDLE, no class_valid, sweep_count unchanged.
- Assert reset during WAIT, then a DRDY arrives -> all outputs 0 and samples stay 0. With XADC_CLASS_IIR_EN, a constant DO=0x8000 makes samples[0] go 0x200, 0x380, 0x4A0... converging to 0x800.
